// File: rtl/ramsp_ctrl.sv
// Request front end for a single-port no-change RAM: zero-fills the RAM after reset,
// then turns a valid/ready request stream into RAM strobes and returns read data in order.
module ramsp_ctrl #(
  parameter int DW   = 32,
  parameter int AW   = 6,
  parameter int INIT = 1
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_din_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dout_o,
  output logic          init_done_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] fill_cnt_q, fill_cnt_d;
  logic          inflight_q, inflight_d;
  logic [DW-1:0] buf_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic       run;
  logic       acc;
  logic       push;
  logic       pop;
  logic [1:0] occ;

  assign run  = (state_q == ST_RUN);
  assign occ  = count_q + {1'b0, inflight_q};
  assign pop  = (count_q != 2'd0) & rsp_ready_i;
  assign push = inflight_q;

  // A pop this cycle frees a slot, so a full buffer can still take a request.
  assign req_ready_o = nreset_i & run & ((occ < 2'd2) | pop);
  assign acc         = req_valid_i & req_ready_o;
  assign rsp_valid_o = nreset_i & (count_q != 2'd0);
  assign rsp_dout_o  = nreset_i ? buf_q[rd_ptr_q] : '0;
  assign init_done_o = nreset_i & run;

  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (nreset_i) begin
      if (!run) begin
        mem_en_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = fill_cnt_q;
      end else begin
        mem_en_o   = acc;
        mem_we_o   = acc & req_we_i;
        mem_addr_o = req_addr_i;
        mem_din_o  = req_din_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (!run) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
      if (fill_cnt_q == {AW{1'b1}}) begin
        state_d = ST_RUN;
      end
    end
    inflight_d = acc & ~req_we_i;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= (INIT != 0) ? ST_FILL : ST_RUN;
      fill_cnt_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // RAM read data lands in the buffer one cycle after the read strobe.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
        buf_q[gi] <= '0;
      end else if (push && (wr_ptr_q == gi[0])) begin
        buf_q[gi] <= mem_dout_i;
      end
    end
  end

endmodule
